// File: rtl/vdc_pkg.sv
// Shared constants for the VDC video output slice: character width,
// attribute byte bit positions and the cursor display mode encoding.
package vdc_pkg;

    localparam int unsigned CHAR_W         = 8;

    // Attribute byte layout
    localparam int unsigned ATTR_RVS_BIT   = 6;
    localparam int unsigned ATTR_UL_BIT    = 5;
    localparam int unsigned ATTR_BLINK_BIT = 4;
    localparam int unsigned ATTR_FG_MSB    = 3;
    localparam int unsigned ATTR_FG_LSB    = 0;

    typedef enum logic [1:0] {
        SOLID   = 2'b00,
        OFF     = 2'b01,
        BLINK16 = 2'b10,
        BLINK32 = 2'b11
    } cursor_mode_e;

    // Whether the cursor is currently in its visible phase
    function automatic logic cursor_phase(input cursor_mode_e mode, input logic [1:0] blink);
        logic on;
        case (mode)
            SOLID:   on = 1'b1;
            OFF:     on = 1'b0;
            BLINK16: on = blink[0];
            BLINK32: on = blink[1];
            default: on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/vdc_shifter.sv
// Character bitmap shift register with optional pixel doubling.
// pix_bit is the bitmap bit for the current pixel; on a load cycle it comes
// straight from char_bits so the output path sees no extra latency.
module vdc_shifter
    import vdc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable0,
    input  logic              new_col,
    input  logic              pix_lsb,
    input  logic              reg_dbl,
    input  logic [CHAR_W-1:0] char_bits,
    output logic              pix_bit
);

    logic [CHAR_W-1:0] sr_q;
    logic [CHAR_W-1:0] sr_d;
    logic [CHAR_W-1:0] src;

    // Select load vs. held byte, emit MSB, and advance after the pixel is consumed
    always_comb begin
        src     = new_col ? char_bits : sr_q;
        pix_bit = src[CHAR_W-1];
        sr_d    = sr_q;
        if (enable0) begin
            // A load on a shifting pixel stores the already-advanced byte,
            // so the load wins and the following pixel still sees the next bit.
            if (!reg_dbl || pix_lsb) begin
                sr_d = {src[CHAR_W-2:0], 1'b0};
            end else begin
                sr_d = src;
            end
        end
    end

    // Shift register state
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/vdc_video_out.sv
// VDC video output stage: turns the character bitmap, attribute byte and
// cursor state into a registered RGBI pixel, one enable0 cycle of latency.
// Optional cursor logic is built when VDC_CURSOR_EN is defined.
module vdc_video_out
    import vdc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable0,
    input  logic       newCol,
    input  logic       endCol,
    input  logic [4:0] pixel,
    input  logic [4:0] line,
    input  logic       hVisible,
    input  logic       vVisible,
    input  logic       display,
    input  logic       hblank,
    input  logic       vblank,
    input  logic [1:0] blink,
    input  logic [7:0] char_bits,
    input  logic [7:0] attr,
    input  logic       cursor,
    input  logic [3:0] reg_cdh,
    input  logic       reg_dbl,
    input  logic [3:0] reg_fg,
    input  logic [3:0] reg_bg,
    input  logic       reg_atr,
    input  logic       reg_rvs,
    input  logic [4:0] reg_ul,
    input  logic [1:0] reg_cm,
    input  logic [4:0] reg_cs,
    input  logic [4:0] reg_ce,
    output logic [3:0] rgbi
);

    logic [7:0] attr_q,   attr_d;
    logic       cursor_q, cursor_d;
    logic [4:0] line_q,   line_d;
    logic       valid_q,  valid_d;
    logic [3:0] rgbi_q,   rgbi_d;

    logic [7:0] cur_attr;
    logic       cur_cursor;
    logic [4:0] cur_line;
    logic       shift_bit;
    logic       pix;
    logic       attr_rvs;
    logic       attr_ul;
    logic       attr_blk;
    logic [3:0] fg_col;
    logic [3:0] colour;

    // endCol carries no information this stage needs
    logic unused_end_col;
    assign unused_end_col = endCol;

    vdc_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .enable0   (enable0),
        .new_col   (newCol),
        .pix_lsb   (pixel[0]),
        .reg_dbl   (reg_dbl),
        .char_bits (char_bits),
        .pix_bit   (shift_bit)
    );

    // Capture per-column attribute, cursor and line at the first pixel
    always_comb begin
        attr_d   = attr_q;
        cursor_d = cursor_q;
        line_d   = line_q;
        valid_d  = valid_q;
        if (enable0 && newCol) begin
            attr_d   = attr;
            cursor_d = cursor;
            line_d   = line;
            valid_d  = 1'b1;
        end
    end

    // Pixel modifiers, colour select and blanking
    always_comb begin
        cur_attr   = newCol ? attr   : attr_q;
        cur_cursor = newCol ? cursor : cursor_q;
        cur_line   = newCol ? line   : line_q;

        fg_col   = reg_atr ? cur_attr[ATTR_FG_MSB:ATTR_FG_LSB] : reg_fg;
        attr_rvs = reg_atr & cur_attr[ATTR_RVS_BIT];
        attr_ul  = reg_atr & cur_attr[ATTR_UL_BIT];
        attr_blk = reg_atr & cur_attr[ATTR_BLINK_BIT];

        // Pixels beyond the character width are gap (background)
        pix = shift_bit & (pixel < {1'b0, reg_cdh});
        if (attr_ul && (cur_line == reg_ul)) begin
            pix = 1'b1;
        end
        if (attr_blk && !blink[1]) begin
            pix = 1'b0;
        end
`ifdef VDC_CURSOR_EN
        if (cur_cursor && (cur_line >= reg_cs) && (cur_line <= reg_ce) &&
            cursor_phase(cursor_mode_e'(reg_cm), blink)) begin
            pix = ~pix;
        end
`endif
        colour = (pix ^ attr_rvs ^ reg_rvs) ? fg_col : reg_bg;

        rgbi_d = rgbi_q;
        if (enable0) begin
            if (hblank || vblank || !display) begin
                rgbi_d = '0;
            end else if (!(valid_q || newCol)) begin
                // After reset nothing is shown until a column has been loaded
                rgbi_d = '0;
            end else if (!hVisible || !vVisible) begin
                rgbi_d = reg_bg;
            end else begin
                rgbi_d = colour;
            end
        end
    end

`ifndef VDC_CURSOR_EN
    logic unused_cursor;
    assign unused_cursor = ^{cur_cursor, reg_cm, reg_cs, reg_ce};
`endif

    // Column latches and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            attr_q   <= '0;
            cursor_q <= 1'b0;
            line_q   <= '0;
            valid_q  <= 1'b0;
            rgbi_q   <= '0;
        end else begin
            attr_q   <= attr_d;
            cursor_q <= cursor_d;
            line_q   <= line_d;
            valid_q  <= valid_d;
            rgbi_q   <= rgbi_d;
        end
    end

    assign rgbi = rgbi_q;

endmodule

// File: tb/tb_vdc_video_out.sv
// Directed testbench for vdc_video_out.
module tb_vdc_video_out;

    logic       clk;
    logic       reset;
    logic       enable0;
    logic       newCol;
    logic       endCol;
    logic [4:0] pixel;
    logic [4:0] line;
    logic       hVisible;
    logic       vVisible;
    logic       display;
    logic       hblank;
    logic       vblank;
    logic [1:0] blink;
    logic [7:0] char_bits;
    logic [7:0] attr;
    logic       cursor;
    logic [3:0] reg_cdh;
    logic       reg_dbl;
    logic [3:0] reg_fg;
    logic [3:0] reg_bg;
    logic       reg_atr;
    logic       reg_rvs;
    logic [4:0] reg_ul;
    logic [1:0] reg_cm;
    logic [4:0] reg_cs;
    logic [4:0] reg_ce;
    logic [3:0] rgbi;

    int n_cmp = 0;
    int n_err = 0;

    vdc_video_out dut (
        .clk       (clk),
        .reset     (reset),
        .enable0   (enable0),
        .newCol    (newCol),
        .endCol    (endCol),
        .pixel     (pixel),
        .line      (line),
        .hVisible  (hVisible),
        .vVisible  (vVisible),
        .display   (display),
        .hblank    (hblank),
        .vblank    (vblank),
        .blink     (blink),
        .char_bits (char_bits),
        .attr      (attr),
        .cursor    (cursor),
        .reg_cdh   (reg_cdh),
        .reg_dbl   (reg_dbl),
        .reg_fg    (reg_fg),
        .reg_bg    (reg_bg),
        .reg_atr   (reg_atr),
        .reg_rvs   (reg_rvs),
        .reg_ul    (reg_ul),
        .reg_cm    (reg_cm),
        .reg_cs    (reg_cs),
        .reg_ce    (reg_ce),
        .rgbi      (rgbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        n_cmp++;
        assert (rgbi === exp) else begin
            n_err++;
            $error("FAIL %s: rgbi=%h expected=%h", tag, rgbi, exp);
        end
    endtask

    // Drive one pixel of a column; column data is valid on p==0 and
    // deliberately corrupted afterwards to prove it was latched.
    task automatic drive_pix(input int unsigned p, input logic [7:0] cb,
                             input logic [7:0] at, input logic cur, input logic [4:0] ln);
        newCol    = (p == 0);
        endCol    = (p == 7);
        pixel     = p[4:0];
        char_bits = (p == 0) ? cb  : ~cb;
        attr      = (p == 0) ? at  : ~at;
        cursor    = (p == 0) ? cur : ~cur;
        line      = (p == 0) ? ln  : ~ln;
    endtask

    // exp holds 8 nibbles, pixel 0 in the most significant nibble
    task automatic run_col(input string tag, input logic [7:0] cb, input logic [7:0] at,
                           input logic cur, input logic [4:0] ln, input logic [31:0] exp);
        for (int unsigned p = 0; p < 8; p++) begin
            drive_pix(p, cb, at, cur, ln);
            tick();
            chk($sformatf("%s_p%0d", tag, p), exp[(7 - p) * 4 +: 4]);
        end
    endtask

    initial begin
        logic [31:0] exp_cur;

        reset = 1'b1; enable0 = 1'b1; newCol = 1'b0; endCol = 1'b0;
        pixel = '0; line = '0; hVisible = 1'b1; vVisible = 1'b1;
        display = 1'b1; hblank = 1'b0; vblank = 1'b0; blink = 2'b11;
        char_bits = '0; attr = '0; cursor = 1'b0;
        reg_cdh = 4'd8; reg_dbl = 1'b0; reg_fg = 4'hF; reg_bg = 4'h0;
        reg_atr = 1'b0; reg_rvs = 1'b0; reg_ul = 5'd31; reg_cm = 2'b01;
        reg_cs = 5'd0; reg_ce = 5'd7;

        tick();
        tick();
        chk("reset", 4'h0);
        reset = 1'b0;

        // Plain bitmap, single width
        run_col("a5", 8'hA5, 8'h00, 1'b0, 5'd3, 32'hF0F0_0F0F);

        // Double width
        reg_dbl = 1'b1;
        run_col("a5_dbl", 8'hA5, 8'h00, 1'b0, 5'd3, 32'hFF00_FF00);

        // Narrow character with visible gap colour
        reg_cdh = 4'd4; reg_bg = 4'h2;
        run_col("a5_cdh4", 8'hA5, 8'h00, 1'b0, 5'd3, 32'hFF22_2222);
        reg_cdh = 4'd8; reg_bg = 4'h0; reg_dbl = 1'b0;

        // Underline + blink attribute
        reg_atr = 1'b1; reg_ul = 5'd3;
        run_col("ul_on", 8'hA5, 8'h35, 1'b0, 5'd3, 32'h5555_5555);
        blink = 2'b01;
        run_col("ul_blk", 8'hA5, 8'h35, 1'b0, 5'd3, 32'h0000_0000);
        blink = 2'b11; reg_ul = 5'd31;

        // Attribute reverse
        run_col("attr_rvs", 8'hA5, 8'h4C, 1'b0, 5'd3, 32'h0C0C_C0C0);
        reg_atr = 1'b0;

        // Screen reverse
        reg_rvs = 1'b1;
        run_col("scr_rvs", 8'hA5, 8'h00, 1'b0, 5'd3, 32'h0F0F_F0F0);
        reg_rvs = 1'b0;

        // Cursor solid / off
`ifdef VDC_CURSOR_EN
        exp_cur = 32'hFFFF_FFFF;
`else
        exp_cur = 32'h0000_0000;
`endif
        reg_cm = 2'b00;
        run_col("cur_solid", 8'h00, 8'h00, 1'b1, 5'd3, exp_cur);
        reg_cm = 2'b01;
        run_col("cur_off", 8'h00, 8'h00, 1'b1, 5'd3, 32'h0000_0000);

        // Blanking and visibility mid-column
        reg_bg = 4'h6;
        drive_pix(0, 8'hFF, 8'h00, 1'b0, 5'd3); tick(); chk("blank_p0", 4'hF);
        drive_pix(1, 8'hFF, 8'h00, 1'b0, 5'd3); tick(); chk("blank_p1", 4'hF);
        drive_pix(2, 8'hFF, 8'h00, 1'b0, 5'd3); hblank = 1'b1;
        tick(); chk("hblank", 4'h0);
        drive_pix(3, 8'hFF, 8'h00, 1'b0, 5'd3); hblank = 1'b0; vVisible = 1'b0;
        tick(); chk("vvis", 4'h6);
        drive_pix(4, 8'hFF, 8'h00, 1'b0, 5'd3); vVisible = 1'b1; display = 1'b0;
        tick(); chk("display", 4'h0);
        drive_pix(5, 8'hFF, 8'h00, 1'b0, 5'd3); display = 1'b1; vblank = 1'b1;
        tick(); chk("vblank", 4'h0);
        drive_pix(6, 8'hFF, 8'h00, 1'b0, 5'd3); vblank = 1'b0;
        tick(); chk("blank_p6", 4'hF);

        // Output holds while enable0 is low, and the shifter does not advance
        reg_bg = 4'h0;
        drive_pix(0, 8'hA5, 8'h00, 1'b0, 5'd3); tick(); chk("hold_p0", 4'hF);
        drive_pix(1, 8'hA5, 8'h00, 1'b0, 5'd3); enable0 = 1'b0;
        tick(); chk("hold_a", 4'hF);
        tick(); chk("hold_b", 4'hF);
        enable0 = 1'b1;
        tick(); chk("hold_p1", 4'h0);
        drive_pix(2, 8'hA5, 8'h00, 1'b0, 5'd3); tick(); chk("hold_p2", 4'hF);

        // Reset mid-column: dark until the next column load
        reg_bg = 4'h6;
        drive_pix(0, 8'hFF, 8'h00, 1'b0, 5'd3); tick(); chk("rst_p0", 4'hF);
        drive_pix(1, 8'hFF, 8'h00, 1'b0, 5'd3); tick(); chk("rst_p1", 4'hF);
        drive_pix(2, 8'hFF, 8'h00, 1'b0, 5'd3); reset = 1'b1;
        tick(); chk("rst_mid", 4'h0);
        reset = 1'b0;
        for (int unsigned p = 3; p < 8; p++) begin
            drive_pix(p, 8'hFF, 8'h00, 1'b0, 5'd3);
            tick();
            chk($sformatf("rst_dark_p%0d", p), 4'h0);
        end
        drive_pix(0, 8'hFF, 8'h00, 1'b0, 5'd3); tick(); chk("rst_new_p0", 4'hF);
        drive_pix(1, 8'hFF, 8'h00, 1'b0, 5'd3); tick(); chk("rst_new_p1", 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
